// File: rtl/tribus_arbiter.sv
// tribus_arbiter: two-driver ownership arbiter for a shared tri-state bus.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | nobody drives; requests are evaluated here only
//   OWN0   | driver 0 owns the bus (en0=1), hold_cnt counts owned cycles
//   OWN1   | driver 1 owns the bus (en1=1), hold_cnt counts owned cycles
//   TURN   | dead time with both enables low, lasts TURN_CYC cycles
//
// Each owner may keep the bus for MAXHOLD cycles while the other side is
// waiting. A sole requester keeps the bus without limit. The
// priority pointer flips to the other side on every release, which gives
// round-robin behaviour under permanent contention. Every output comes
// straight from a flop, so the next-cycle output values are computed
// alongside the next state.
module tribus_arbiter #(
    parameter int MAXHOLD  = 4,
    parameter int TURN_CYC = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    output logic       en0,
    output logic       en1,
    output logic       busy,
    output logic [7:0] hold_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2,
        ST_TURN = 2'd3
    } state_e;

    localparam logic [7:0] MAXHOLD_C  = 8'(MAXHOLD);
    localparam logic [3:0] TURN_CYC_C = 4'(TURN_CYC);
    localparam logic [7:0] HOLD_SAT   = 8'hFF;

    state_e     state_q, state_d;
    logic       prio_q, prio_d;
    logic [7:0] hold_q, hold_d;
    logic [3:0] turn_q, turn_d;
    logic       en0_q, en0_d;
    logic       en1_q, en1_d;
    logic       busy_q, busy_d;

    logic       own_req;
    logic       oth_req;
    logic       release_own;

    // Next state, pointer, hold counter and turnaround down-counter.
    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        hold_d      = hold_q;
        turn_d      = turn_q;
        own_req     = 1'b0;
        oth_req     = 1'b0;
        release_own = 1'b0;

        case (state_q)
            ST_IDLE: begin
                hold_d = 8'd0;
                turn_d = 4'd0;
                if (req0 && req1) begin
                    state_d = prio_q ? ST_OWN1 : ST_OWN0;
                    hold_d  = 8'd1;
                end else if (req0) begin
                    state_d = ST_OWN0;
                    hold_d  = 8'd1;
                end else if (req1) begin
                    state_d = ST_OWN1;
                    hold_d  = 8'd1;
                end
            end

            ST_OWN0, ST_OWN1: begin
                own_req = (state_q == ST_OWN0) ? req0 : req1;
                oth_req = (state_q == ST_OWN0) ? req1 : req0;
                // Forced release only applies when the other side waits;
                // a sole owner simply lets hold_cnt saturate.
                release_own = !own_req || (oth_req && (hold_q >= MAXHOLD_C));
                if (release_own) begin
                    state_d = ST_TURN;
                    prio_d  = (state_q == ST_OWN0);
                    hold_d  = 8'd0;
                    turn_d  = TURN_CYC_C;
                end else if (hold_q != HOLD_SAT) begin
                    hold_d = hold_q + 8'd1;
                end
            end

            ST_TURN: begin
                hold_d = 8'd0;
                // Terminal count at 1: the cycle holding 1 is the last TURN cycle.
                if (turn_q <= 4'd1) begin
                    state_d = ST_IDLE;
                    turn_d  = 4'd0;
                end else begin
                    turn_d = turn_q - 4'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                hold_d  = 8'd0;
                turn_d  = 4'd0;
            end
        endcase
    end

    // Registered outputs are derived from the next state so they line up with it.
    always_comb begin
        en0_d  = (state_d == ST_OWN0);
        en1_d  = (state_d == ST_OWN1);
        busy_d = (state_d != ST_IDLE);
    end

    // State, pointer, counters and output flops; reset releases the bus at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            prio_q  <= 1'b0;
            hold_q  <= 8'd0;
            turn_q  <= 4'd0;
            en0_q   <= 1'b0;
            en1_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            hold_q  <= hold_d;
            turn_q  <= turn_d;
            en0_q   <= en0_d;
            en1_q   <= en1_d;
            busy_q  <= busy_d;
        end
    end

    assign en0      = en0_q;
    assign en1      = en1_q;
    assign busy     = busy_q;
    assign hold_cnt = hold_q;

endmodule
